// File: rtl/seq_ctrl_pkg.sv
// Shared constants and state encoding for the Sequencia session controller.
package seq_ctrl_pkg;

  localparam int W_DEF  = 8;
  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLR    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CLR    = ST_CLR,
    LOAD   = ST_LOAD,
    STREAM = ST_STREAM,
    FLUSH  = ST_FLUSH,
    DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/controlador_sequencia_serializador_byte.sv
// Two-entry byte buffer (shifter + holding register) emitting one bit per cycle, MSB first.
module serializador_byte
  import seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              bit_saida,
  output logic              bit_valid,
  output logic              ultimo_bit,
  output logic              underrun
);

  logic [BYTE_W-1:0] sh_data;
  logic [BYTE_W-1:0] hold_data;
  logic [2:0]        sh_cnt;
  logic              sh_valid;
  logic              hold_valid;

  assign bit_valid  = enable && sh_valid;
  assign ultimo_bit = bit_valid && (sh_cnt == 3'd7);
  assign underrun   = ultimo_bit && !hold_valid;
  // The holding slot frees up on the 8th bit, so a byte may be taken that same cycle.
  assign in_ready   = enable && (!hold_valid || ultimo_bit);
  assign bit_saida  = sh_data[BYTE_W-1];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sh_data    <= '0;
      hold_data  <= '0;
      sh_cnt     <= 3'd0;
      sh_valid   <= 1'b0;
      hold_valid <= 1'b0;
    end else if (bit_valid) begin
      if (sh_cnt == 3'd7) begin
        sh_cnt     <= 3'd0;
        sh_data    <= hold_data;
        sh_valid   <= hold_valid;
        hold_valid <= in_valid;
        if (in_valid) hold_data <= in_data;
      end else begin
        sh_cnt  <= sh_cnt + 3'd1;
        sh_data <= {sh_data[BYTE_W-2:0], 1'b0};
        if (in_valid) begin
          hold_valid <= 1'b1;
          hold_data  <= in_data;
        end
      end
    end else if (in_valid) begin
      sh_valid <= 1'b1;
      sh_data  <= in_data;
      sh_cnt   <= 3'd0;
    end
  end

endmodule

// File: rtl/controlador_sequencia.sv
// Session controller: clears and loads the detector, streams bytes into it, and captures the first match.
module controlador_sequencia
  import seq_ctrl_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [W-1:0]      cfg_palavra,
  output logic              cfg_ready,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              det_rst_n,
  output logic              det_setar_palavra,
  output logic [W-1:0]      det_palavra,
  output logic              det_start,
  output logic              det_bit_in,
  input  logic              det_encontrado,
  output logic              achado,
  output logic [CW-1:0]     posicao,
  output logic              concluido,
  output logic              erro,
  output logic [2:0]        estado
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both high;
  // ready never depends on valid, and the offerer holds its data stable until the transfer.

  state_t        state, state_next;
  logic [W-1:0]  pal_reg;
  logic          last_acc;
  logic          det_hold;
  logic [CW-1:0] idx, idx_d;
  logic          bv_d;

  logic ser_ready, ser_bit, bit_valid, ultimo_bit, underrun;
  logic accept;

  assign estado     = state;
  assign byte_ready = ser_ready && !last_acc;
  assign accept     = byte_valid && byte_ready;

  serializador_byte u_ser (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != STREAM),
    .enable     (state == STREAM),
    .in_valid   (accept),
    .in_data    (byte_data),
    .in_ready   (ser_ready),
    .bit_saida  (ser_bit),
    .bit_valid  (bit_valid),
    .ultimo_bit (ultimo_bit),
    .underrun   (underrun)
  );

  always_comb begin
    state_next        = state;
    cfg_ready         = 1'b0;
    det_rst_n         = !det_hold;
    det_setar_palavra = 1'b0;
    det_palavra       = '0;
    det_start         = 1'b0;
    det_bit_in        = 1'b0;
    concluido         = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_next = CLR;
      end
      CLR: begin
        det_rst_n  = 1'b0;
        state_next = LOAD;
      end
      LOAD: begin
        det_setar_palavra = 1'b1;
        det_palavra       = pal_reg;
        state_next        = STREAM;
      end
      STREAM: begin
        // Keep the detector frozen in load mode until the first real bit is available.
        if (!bit_valid) begin
          det_setar_palavra = 1'b1;
          det_palavra       = pal_reg;
        end else begin
          det_bit_in = ser_bit;
          det_start  = (idx == '0);
        end
        if (underrun) state_next = FLUSH;
      end
      FLUSH: state_next = DONE;
      DONE: begin
        concluido  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      det_hold <= 1'b1;
      pal_reg  <= '0;
      last_acc <= 1'b0;
      achado   <= 1'b0;
      posicao  <= '0;
      erro     <= 1'b0;
      idx      <= '0;
      idx_d    <= '0;
      bv_d     <= 1'b0;
    end else begin
      state <= state_next;
      bv_d  <= bit_valid;
      if (state == IDLE && cfg_valid) begin
        det_hold <= 1'b0;
        pal_reg  <= cfg_palavra;
        last_acc <= 1'b0;
        achado   <= 1'b0;
        posicao  <= '0;
        erro     <= 1'b0;
        idx      <= '0;
      end
      if (accept && byte_last) last_acc <= 1'b1;
      if (bit_valid) begin
        idx_d <= idx;
        if (idx != '1) idx <= idx + CW'(1);
      end
      // idx_d trails the detector's one-cycle latency, so it names the bit that completed the match.
      if (bv_d && det_encontrado && !achado) begin
        achado  <= 1'b1;
        posicao <= idx_d;
      end
      if (underrun && !last_acc) erro <= 1'b1;
    end
  end

endmodule

// File: tb/tb_controlador_sequencia.sv
// Directed and randomized sessions against a bit-stream reference model and a behavioural detector.
module tb_controlador_sequencia;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [W-1:0]  cfg_palavra;
  logic          cfg_ready;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_last;
  logic          byte_ready;
  logic          det_rst_n;
  logic          det_setar_palavra;
  logic [W-1:0]  det_palavra;
  logic          det_start;
  logic          det_bit_in;
  logic          det_encontrado;
  logic          achado;
  logic [CW-1:0] posicao;
  logic          concluido;
  logic          erro;
  logic [2:0]    estado;

  controlador_sequencia #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_palavra(cfg_palavra), .cfg_ready(cfg_ready),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
    .det_rst_n(det_rst_n), .det_setar_palavra(det_setar_palavra), .det_palavra(det_palavra),
    .det_start(det_start), .det_bit_in(det_bit_in), .det_encontrado(det_encontrado),
    .achado(achado), .posicao(posicao), .concluido(concluido), .erro(erro), .estado(estado)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural detector ----------------
  logic [W-1:0] det_hist, det_pal;
  logic         det_found;
  assign det_encontrado = det_found;

  always @(posedge clk) begin
    if (!det_rst_n) begin
      det_hist  <= '0;
      det_pal   <= '0;
      det_found <= 1'b0;
    end else if (det_setar_palavra) begin
      det_pal <= det_palavra;
    end else begin
      det_hist <= {det_hist[W-2:0], det_bit_in};
      if ({det_hist[W-2:0], det_bit_in} == det_pal) det_found <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reassemble the serialized bits into bytes and compare against the queued stream.
  int         start_cyc = 0;
  bit         collecting = 0;
  int         nbits = 0;
  logic [7:0] mon_sh;

  always @(negedge clk) begin
    if (rst) begin
      collecting = 0;
      nbits      = 0;
    end else begin
      if (det_start) begin
        collecting = 1;
        start_cyc  = cyc;
        nbits      = 0;
      end
      if (collecting) begin
        mon_sh = {mon_sh[6:0], det_bit_in};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (exp_q.size() > 0) check("stream_byte", {24'd0, mon_sh}, {24'd0, exp_q.pop_front()});
          else check("stream_extra", 32'd1, 32'd0);
          if (exp_q.size() == 0) collecting = 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // First index whose trailing 8 bits (zeros before the stream) equal the pattern.
  function automatic void model(input logic [7:0] pat, input logic [7:0] bq[$],
                                output logic found, output int pos);
    logic [7:0] win = 8'd0;
    logic [7:0] cur;
    int k = 0;
    found = 1'b0;
    pos   = 0;
    foreach (bq[i]) begin
      cur = bq[i];
      for (int b = 7; b >= 0; b--) begin
        win = {win[6:0], cur[b]};
        if (!found && win == pat) begin
          found = 1'b1;
          pos   = k;
        end
        k++;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic offer_cfg(input logic [7:0] pat);
    bit ok = 0;
    cfg_valid   = 1'b1;
    cfg_palavra = pat;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = cfg_ready;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    if (!ok) check("cfg_accept", 32'd0, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    bit ok = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("byte_accept", 32'd0, 32'd1);
  endtask

  task automatic run_session(input string name, input logic [7:0] pat, input logic [7:0] bq[$],
                             input bit send_last, input int pre_gap);
    logic f;
    int   pos;
    int   n = bq.size();
    bit   got = 0;
    model(pat, bq, f, pos);
    foreach (bq[i]) exp_q.push_back(bq[i]);
    offer_cfg(pat);
    repeat (pre_gap) begin @(posedge clk); #1; end
    foreach (bq[i]) send_byte(bq[i], send_last && (i == n - 1));
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (concluido) got = 1;
    end
    check({name, "_concluido"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({name, "_achado"}, {31'd0, achado}, {31'd0, f});
      if (f) check({name, "_posicao"}, {16'd0, posicao}, pos);
      check({name, "_erro"}, {31'd0, erro}, {31'd0, !send_last});
      check({name, "_latency"}, cyc - start_cyc, 8 * n + 1);
    end
    check({name, "_bytes_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clk);
    check({name, "_pulse"}, {31'd0, concluido}, 32'd0);
    check({name, "_hold"}, {31'd0, achado}, {31'd0, f});
    check({name, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] bq[$];
  logic [7:0] pat, tmp;
  int         n, off, bi, seen;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_palavra = '0;
    byte_valid = 1'b0; byte_data = '0; byte_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_det_rst_n", {31'd0, det_rst_n}, 32'd0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_achado", {31'd0, achado}, 32'd0);
    check("rst_posicao", {16'd0, posicao}, 32'd0);
    check("rst_erro", {31'd0, erro}, 32'd0);
    check("rst_concluido", {31'd0, concluido}, 32'd0);
    check("rst_setar", {31'd0, det_setar_palavra}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    bq = '{8'h00, 8'hA5};
    run_session("t1", 8'hA5, bq, 1, 0);
    bq = '{8'h03, 8'hC0};
    run_session("t2", 8'h3C, bq, 1, 2);
    bq = '{8'h12, 8'h34};
    run_session("t3", 8'hFF, bq, 1, 0);
    bq = '{8'h11};
    run_session("t4", 8'h5A, bq, 0, 0);
    bq = '{8'hC3};
    run_session("t5a", 8'hC3, bq, 1, 1);
    bq = '{8'h00};
    run_session("t5b", 8'h81, bq, 1, 0);

    for (int r = 0; r < 12; r++) begin
      pat = 8'($urandom_range(0, 255));
      n   = $urandom_range(1, 4);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        off = $urandom_range(0, 8 * n - 8);
        for (int j = 0; j < 8; j++) begin
          bi = off + j;
          tmp = bq[bi / 8];
          tmp[7 - (bi % 8)] = pat[7 - j];
          bq[bi / 8] = tmp;
        end
      end
      run_session("rnd", pat, bq, 1, $urandom_range(0, 3));
    end

    // Reset in the middle of a byte.
    offer_cfg(8'hFF);
    byte_valid = 1'b1; byte_data = 8'hF0; byte_last = 1'b0;
    seen = 0;
    for (int t = 0; t < 50 && seen == 0; t++) begin
      @(negedge clk);
      if (det_start) seen = 1;
    end
    check("t6_start_seen", seen, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_det_rst_n", {31'd0, det_rst_n}, 32'd0);
    check("t6_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("t6_achado", {31'd0, achado}, 32'd0);
    check("t6_erro", {31'd0, erro}, 32'd0);
    check("t6_bit_in", {31'd0, det_bit_in}, 32'd0);
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (concluido) seen++;
    end
    check("t6_no_concluido", seen, 32'd0);
    check("t6_still_held", {31'd0, det_rst_n}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
